decode_queue: RTL and testbench

- Registered, parametrised control decoder for the RV32I core.
- Accepts raw 32-bit instructions over a valid/ready handshake and decodes opcode/funct3/funct7 into the control bundle (Branch, jumpSrc, jalrSrc, resultSrc, memWrite, aluSrc, immSrc, regWrite, aluOp, sizeSrc).
- Holds decoded bundles in a DEPTH-entry FIFO feeding the execute stage.
- Adds illegal-instruction detection, optional LUI and M-extension decode, synchronous flush, and a saturating illegal-instruction counter.

---
 rtl/decode_queue.sv | 206 ++++++++++++++++++++
 tb/tb_decode_queue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// RV32I control decoder with a DEPTH-entry queue of decoded bundles feeding execute.
// Flags illegal encodings, keeps them in order, and counts them in a saturating counter.
module decode_queue #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned EN_UPPER = 1,
    parameter int unsigned EN_MEXT  = 0,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             Branch,
    output logic             jumpSrc,
    output logic             jalrSrc,
    output logic [1:0]       resultSrc,
    output logic             memWrite,
    output logic             aluSrc,
    output logic [2:0]       immSrc,
    output logic             regWrite,
    output logic [1:0]       aluOp,
    output logic [2:0]       sizeSrc,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);
    localparam int unsigned LAST     = DEPTH - 1;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef struct packed {
        logic       branch;
        logic       jump_src;
        logic       jalr_src;
        logic [1:0] result_src;
        logic       mem_write;
        logic       alu_src;
        logic [2:0] imm_src;
        logic       reg_write;
        logic [1:0] alu_op;
        logic [2:0] size_src;
        logic       illegal;
    } ctrl_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    ctrl_t      dec;
    ctrl_t      head;
    ctrl_t      mem [DEPTH];

    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_BITS-1:0] count;
    logic                push;
    logic                pop;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Instruction decode; illegal encodings leave every control field at zero.
    always_comb begin
        dec = '0;
        case (opcode)
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                dec.imm_src    = 3'b011;
                dec.alu_src    = 1'b1;
                dec.result_src = 2'b10;
                dec.jump_src   = 1'b1;
            end
            OP_JALR: begin
                dec.reg_write  = 1'b1;
                dec.imm_src    = 3'b000;
                dec.alu_src    = 1'b1;
                dec.result_src = 2'b10;
                dec.jump_src   = 1'b1;
                dec.jalr_src   = 1'b1;
            end
            OP_BRANCH: begin
                dec.branch  = 1'b1;
                dec.imm_src = 3'b010;
                dec.alu_op  = 2'b01;
            end
            OP_LOAD: begin
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.reg_write  = 1'b1;
                    dec.alu_src    = 1'b1;
                    dec.result_src = 2'b01;
                    dec.size_src   = funct3;
                end
            end
            OP_STORE: begin
                if (funct3 > 3'b010) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.mem_write = 1'b1;
                    dec.alu_src   = 1'b1;
                    dec.imm_src   = 3'b001;
                    dec.size_src  = funct3;
                end
            end
            OP_IMM: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = 2'b10;
            end
            OP_REG: begin
                if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
                    dec.reg_write = 1'b1;
                    dec.alu_op    = 2'b10;
                end else if (funct7 == 7'b0000001 && EN_MEXT != 0) begin
                    dec.reg_write = 1'b1;
                    dec.alu_op    = 2'b11;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_LUI: begin
                if (EN_UPPER != 0) begin
                    dec.reg_write  = 1'b1;
                    dec.imm_src    = 3'b100;
                    dec.result_src = 2'b11;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // Ready comes only from the registered count so there is no path from out_ready.
    assign in_ready  = (count < CNT_BITS'(DEPTH)) && !rst;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_ready && out_valid;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= dec;
        end
    end

    // Queue bookkeeping; flush wins over push and pop but leaves the illegal count alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            illegal_cnt <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= (wr_ptr == PTR_W'(LAST)) ? '0 : wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= (rd_ptr == PTR_W'(LAST)) ? '0 : rd_ptr + PTR_W'(1);
                end
                if (push && !pop) begin
                    count <= count + CNT_BITS'(1);
                end else if (pop && !push) begin
                    count <= count - CNT_BITS'(1);
                end
            end
            if (push && dec.illegal && illegal_cnt != '1) begin
                illegal_cnt <= illegal_cnt + CNT_W'(1);
            end
        end
    end

    // Head entry is forced to zero whenever the queue is empty.
    assign head = out_valid ? mem[rd_ptr] : '0;

    assign Branch    = head.branch;
    assign jumpSrc   = head.jump_src;
    assign jalrSrc   = head.jalr_src;
    assign resultSrc = head.result_src;
    assign memWrite  = head.mem_write;
    assign aluSrc    = head.alu_src;
    assign immSrc    = head.imm_src;
    assign regWrite  = head.reg_write;
    assign aluOp     = head.alu_op;
    assign sizeSrc   = head.size_src;
    assign illegal   = head.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: default build (a) and DEPTH=3, no LUI, M-ext, 2-bit counter (b).
module tb_decode_queue;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic [31:0] instr;
    logic a_in_valid, a_out_ready, b_in_valid, b_out_ready;

    logic a_in_ready, a_out_valid, a_Branch, a_jumpSrc, a_jalrSrc, a_memWrite, a_aluSrc, a_regWrite, a_illegal;
    logic [1:0] a_resultSrc, a_aluOp;
    logic [2:0] a_immSrc, a_sizeSrc;
    logic [7:0] a_illegal_cnt;

    logic b_in_ready, b_out_valid, b_Branch, b_jumpSrc, b_jalrSrc, b_memWrite, b_aluSrc, b_regWrite, b_illegal;
    logic [1:0] b_resultSrc, b_aluOp;
    logic [2:0] b_immSrc, b_sizeSrc;
    logic [1:0] b_illegal_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    decode_queue dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .instr(instr),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .Branch(a_Branch), .jumpSrc(a_jumpSrc), .jalrSrc(a_jalrSrc), .resultSrc(a_resultSrc),
        .memWrite(a_memWrite), .aluSrc(a_aluSrc), .immSrc(a_immSrc), .regWrite(a_regWrite),
        .aluOp(a_aluOp), .sizeSrc(a_sizeSrc), .illegal(a_illegal), .illegal_cnt(a_illegal_cnt)
    );

    decode_queue #(.DEPTH(3), .EN_UPPER(0), .EN_MEXT(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .instr(instr),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .Branch(b_Branch), .jumpSrc(b_jumpSrc), .jalrSrc(b_jalrSrc), .resultSrc(b_resultSrc),
        .memWrite(b_memWrite), .aluSrc(b_aluSrc), .immSrc(b_immSrc), .regWrite(b_regWrite),
        .aluOp(b_aluOp), .sizeSrc(b_sizeSrc), .illegal(b_illegal), .illegal_cnt(b_illegal_cnt)
    );

    logic [16:0] a_bus, b_bus;
    assign a_bus = {a_Branch, a_jumpSrc, a_jalrSrc, a_resultSrc, a_memWrite, a_aluSrc,
                    a_immSrc, a_regWrite, a_aluOp, a_sizeSrc, a_illegal};
    assign b_bus = {b_Branch, b_jumpSrc, b_jalrSrc, b_resultSrc, b_memWrite, b_aluSrc,
                    b_immSrc, b_regWrite, b_aluOp, b_sizeSrc, b_illegal};

    // Bundle packing: Branch jumpSrc jalrSrc resultSrc memWrite aluSrc immSrc regWrite aluOp sizeSrc illegal
    function automatic logic [16:0] ctl(input logic br, input logic js, input logic jr,
                                        input logic [1:0] rs, input logic mw, input logic as,
                                        input logic [2:0] is, input logic rw, input logic [1:0] ao,
                                        input logic [2:0] ss, input logic il);
        return {br, js, jr, rs, mw, as, is, rw, ao, ss, il};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LW   = 32'h0000A103;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_JAL  = 32'h000000EF;
    localparam logic [31:0] I_BADL = 32'h0000B103;
    localparam logic [31:0] I_BADO = 32'h0000007F;
    localparam logic [31:0] I_LUI  = 32'h123450B7;
    localparam logic [31:0] I_MUL  = 32'h02208033;

    logic [16:0] e_addi, e_lw, e_sw, e_jal, e_lui, e_mul, e_ill;

    initial begin
        e_addi = ctl(0, 0, 0, 2'b00, 0, 1, 3'b000, 1, 2'b10, 3'b000, 0);
        e_lw   = ctl(0, 0, 0, 2'b01, 0, 1, 3'b000, 1, 2'b00, 3'b010, 0);
        e_sw   = ctl(0, 0, 0, 2'b00, 1, 1, 3'b001, 0, 2'b00, 3'b010, 0);
        e_jal  = ctl(0, 1, 0, 2'b10, 0, 1, 3'b011, 1, 2'b00, 3'b000, 0);
        e_lui  = ctl(0, 0, 0, 2'b11, 0, 0, 3'b100, 1, 2'b00, 3'b000, 0);
        e_mul  = ctl(0, 0, 0, 2'b00, 0, 0, 3'b000, 1, 2'b11, 3'b000, 0);
        e_ill  = 17'h00001;

        rst = 1'b1; flush = 1'b0; instr = '0;
        a_in_valid = 1'b0; a_out_ready = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(a_in_ready), 32'd0);
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_bus", 32'(a_bus), 32'd0);
        check("rst_cnt", 32'(a_illegal_cnt), 32'd0);
        rst = 1'b0;
        tick();
        check("rel_in_ready", 32'(a_in_ready), 32'd1);

        // addi: one-cycle latency to the head, then popped
        a_out_ready = 1'b1; a_in_valid = 1'b1; instr = I_ADDI;
        tick();
        a_in_valid = 1'b0;
        check("addi_valid", 32'(a_out_valid), 32'd1);
        check("addi_bus", 32'(a_bus), 32'(e_addi));
        tick();
        check("addi_popped", 32'(a_out_valid), 32'd0);
        check("empty_bus", 32'(a_bus), 32'd0);

        // lw, sw, jal back-to-back with the consumer stalled
        a_out_ready = 1'b0; a_in_valid = 1'b1; instr = I_LW;
        tick();
        check("fill1_ready", 32'(a_in_ready), 32'd1);
        instr = I_SW;
        tick();
        check("full_ready", 32'(a_in_ready), 32'd0);
        instr = I_JAL;
        tick();
        check("full_hold_ready", 32'(a_in_ready), 32'd0);
        check("head_lw", 32'(a_bus), 32'(e_lw));
        a_out_ready = 1'b1;
        tick();
        check("head_sw", 32'(a_bus), 32'(e_sw));
        check("pop_ready", 32'(a_in_ready), 32'd1);
        tick();
        a_in_valid = 1'b0;
        check("head_jal", 32'(a_bus), 32'(e_jal));
        check("pushpop_valid", 32'(a_out_valid), 32'd1);
        tick();
        check("drain_valid", 32'(a_out_valid), 32'd0);

        // illegal load funct3 and illegal opcode
        a_out_ready = 1'b0; a_in_valid = 1'b1; instr = I_BADL;
        tick();
        instr = I_BADO;
        tick();
        a_in_valid = 1'b0;
        check("ill_cnt2", 32'(a_illegal_cnt), 32'd2);
        check("ill_head1", 32'(a_bus), 32'(e_ill));
        a_out_ready = 1'b1;
        tick();
        check("ill_head2", 32'(a_bus), 32'(e_ill));
        tick();
        check("ill_drain", 32'(a_out_valid), 32'd0);

        // 2-bit counter saturates at 3 after five illegals
        b_out_ready = 1'b1; b_in_valid = 1'b1; instr = I_BADO;
        repeat (5) tick();
        b_in_valid = 1'b0;
        check("sat_cnt", 32'(b_illegal_cnt), 32'd3);
        check("sat_head", 32'(b_bus), 32'(e_ill));
        tick();

        // lui and mul on both configurations
        a_in_valid = 1'b1; b_in_valid = 1'b1; instr = I_LUI;
        tick();
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        check("lui_a", 32'(a_bus), 32'(e_lui));
        check("lui_b", 32'(b_bus), 32'(e_ill));
        check("lui_b_cnt", 32'(b_illegal_cnt), 32'd3);
        tick();
        a_in_valid = 1'b1; b_in_valid = 1'b1; instr = I_MUL;
        tick();
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        check("mul_a", 32'(a_bus), 32'(e_ill));
        check("mul_b", 32'(b_bus), 32'(e_mul));
        check("mul_a_cnt", 32'(a_illegal_cnt), 32'd3);
        tick();

        // DEPTH=3 fill and pointer wrap
        b_out_ready = 1'b0; b_in_valid = 1'b1; instr = I_ADDI;
        tick();
        instr = I_LW;
        tick();
        instr = I_SW;
        tick();
        b_in_valid = 1'b0;
        check("b_full_ready", 32'(b_in_ready), 32'd0);
        check("b_head_addi", 32'(b_bus), 32'(e_addi));
        b_out_ready = 1'b1;
        tick();
        check("b_head_lw", 32'(b_bus), 32'(e_lw));
        b_in_valid = 1'b1; instr = I_JAL;
        tick();
        b_in_valid = 1'b0;
        check("b_head_sw", 32'(b_bus), 32'(e_sw));
        tick();
        check("b_head_jal", 32'(b_bus), 32'(e_jal));
        tick();
        check("b_drain", 32'(b_out_valid), 32'd0);

        // flush with a concurrent illegal push: dropped and not counted
        a_out_ready = 1'b0; a_in_valid = 1'b1; instr = I_ADDI;
        tick();
        flush = 1'b1; instr = I_BADO;
        tick();
        flush = 1'b0; a_in_valid = 1'b0;
        check("flush_valid", 32'(a_out_valid), 32'd0);
        check("flush_ready", 32'(a_in_ready), 32'd1);
        check("flush_cnt", 32'(a_illegal_cnt), 32'd3);
        check("flush_bus", 32'(a_bus), 32'd0);
        a_in_valid = 1'b1; instr = I_LW;
        tick();
        a_in_valid = 1'b0;
        check("post_flush_head", 32'(a_bus), 32'(e_lw));

        // asynchronous reset away from any clock edge
        #1 rst = 1'b1;
        #1;
        check("arst_valid", 32'(a_out_valid), 32'd0);
        check("arst_bus", 32'(a_bus), 32'd0);
        check("arst_ready", 32'(a_in_ready), 32'd0);
        check("arst_cnt", 32'(a_illegal_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
